// File: rtl/fetch_stall_ctrl_pkg.sv
// pipe_defs: shared definitions for the fetch stall controller.
package pipe_defs;
    localparam int REG_W = 5;
    localparam logic [0:REG_W-1] REG_ZERO = '0;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mult_state_e;
endpackage

// File: rtl/fetch_stall_ctrl_mult_seq.sv
// mult_seq: multiply sequencer FSM with down-counter holding the front end
// while the multiplier runs.
module mult_seq
    import pipe_defs::*;
#(
    parameter int MULT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mult_start,
    input  logic abort,
    output logic reg_lock_mult,
    output logic mult_busy,
    output logic mult_done
);
    localparam logic [3:0] CNT_INIT = 4'(MULT_CYCLES - 2);

    mult_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (mult_start) begin
                state_d = BUSY;
                cnt_d   = CNT_INIT;
            end
        end else if (abort || cnt_q == 4'd0) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The start cycle locks immediately so the multiply is frozen in ID from the first cycle.
    assign reg_lock_mult = rst_n & ((state_q == IDLE) ? mult_start : (~abort & (cnt_q != 4'd0)));
    assign mult_busy     = rst_n & (state_q == BUSY);
    assign mult_done     = rst_n & (state_q == BUSY) & (cnt_q == 4'd0) & ~abort;
endmodule

// File: rtl/fetch_stall_ctrl.sv
// fetch_stall_ctrl: load-use, multiply and redirect stall/flush control for IF/ID.
// Optional STALL_PERF_CNT_EN adds saturating stall/flush performance counters.
module fetch_stall_ctrl
    import pipe_defs::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int CNT_W       = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [0:REG_W-1] id_rs1,
    input  logic [0:REG_W-1] id_rs2,
    input  logic           id_uses_rs1,
    input  logic           id_uses_rs2,
    input  logic           id_is_mult,
    input  logic [0:REG_W-1] ex_rd,
    input  logic           ex_is_load,
    input  logic           jump_or_branch,
    output logic           reg_lock,
    output logic           reg_lock_mult,
    output logic           bubble_ex,
    output logic           flush_id,
    output logic           mult_busy,
    output logic           mult_done
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [0:CNT_W-1] perf_lu_stalls,
    output logic [0:CNT_W-1] perf_mult_stalls,
    output logic [0:CNT_W-1] perf_flushes
`endif
);
    if (MULT_CYCLES < 2 || MULT_CYCLES > 16 || CNT_W < 1) begin : g_bad_params
        $error("fetch_stall_ctrl: illegal MULT_CYCLES or CNT_W");
    end

    logic load_use, mult_start;

    assign load_use   = ex_is_load & (ex_rd != REG_ZERO) &
                        ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
    // Priority flush > load-use > multiply; mult_busy doubles as "not IDLE".
    assign mult_start = rst_n & id_is_mult & ~load_use & ~jump_or_branch & ~mult_busy;
    assign flush_id   = rst_n & jump_or_branch;
    assign reg_lock   = rst_n & load_use & ~jump_or_branch;
    assign bubble_ex  = reg_lock;

    mult_seq #(.MULT_CYCLES(MULT_CYCLES)) u_mult_seq (
        .clk           (clk),
        .rst_n         (rst_n),
        .mult_start    (mult_start),
        .abort         (jump_or_branch),
        .reg_lock_mult (reg_lock_mult),
        .mult_busy     (mult_busy),
        .mult_done     (mult_done)
    );

`ifdef STALL_PERF_CNT_EN
    logic [0:CNT_W-1] perf_lu_q, perf_mult_q, perf_flush_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_lu_q    <= '0;
            perf_mult_q  <= '0;
            perf_flush_q <= '0;
        end else begin
            if (reg_lock && !(&perf_lu_q))
                perf_lu_q <= perf_lu_q + CNT_W'(1);
            if (reg_lock_mult && !(&perf_mult_q))
                perf_mult_q <= perf_mult_q + CNT_W'(1);
            if (flush_id && !(&perf_flush_q))
                perf_flush_q <= perf_flush_q + CNT_W'(1);
        end
    end

    assign perf_lu_stalls   = perf_lu_q;
    assign perf_mult_stalls = perf_mult_q;
    assign perf_flushes     = perf_flush_q;
`endif
endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// tb_fetch_stall_ctrl: table vectors plus multi-cycle sequences, checked
// through an expected-value queue against MULT_CYCLES=4 and MULT_CYCLES=2 instances.
module tb_fetch_stall_ctrl;
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mult;
        logic [4:0] rd;
        logic       load;
        logic       jb;
    } in_t;

    typedef struct {
        string      name;
        in_t        in;
        logic [5:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        bit         d2;
        logic [5:0] exp;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, id_is_mult = 1'b0;
    logic       ex_is_load = 1'b0, jump_or_branch = 1'b0;
    logic       rl1, rlm1, bx1, fl1, mb1, md1;
    logic       rl2, rlm2, bx2, fl2, mb2, md2;
    int         checks = 0;
    int         fails = 0;
    sb_t        sbq[$];
    vec_t       vecs[12];

    always #5 clk = ~clk;

    fetch_stall_ctrl #(.MULT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_is_mult(id_is_mult),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .jump_or_branch(jump_or_branch),
        .reg_lock(rl1), .reg_lock_mult(rlm1), .bubble_ex(bx1), .flush_id(fl1),
        .mult_busy(mb1), .mult_done(md1)
    );

    fetch_stall_ctrl #(.MULT_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_is_mult(id_is_mult),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .jump_or_branch(jump_or_branch),
        .reg_lock(rl2), .reg_lock_mult(rlm2), .bubble_ex(bx2), .flush_id(fl2),
        .mult_busy(mb2), .mult_done(md2)
    );

    function automatic in_t mk(logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                               logic mult, logic [4:0] rd, logic load, logic jb);
        in_t r;
        r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2;
        r.mult = mult; r.rd = rd; r.load = load; r.jb = jb;
        return r;
    endfunction

    task automatic check_out();
        sb_t        s;
        logic [5:0] got;
        s   = sbq.pop_front();
        got = s.d2 ? {rl2, rlm2, bx2, fl2, mb2, md2} : {rl1, rlm1, bx1, fl1, mb1, md1};
        checks++;
        if (got !== s.exp) begin
            fails++;
            $display("FAIL %s: got {lock,lock_mult,bubble,flush,busy,done}=%b expected %b",
                     s.name, got, s.exp);
        end
    endtask

    task automatic cyc(string nm, in_t i, logic [5:0] e, bit d2 = 1'b0, logic rn = 1'b1);
        sb_t s;
        @(posedge clk);
        #1;
        rst_n = rn;
        id_rs1 = i.rs1; id_rs2 = i.rs2; id_uses_rs1 = i.u1; id_uses_rs2 = i.u2;
        id_is_mult = i.mult; ex_rd = i.rd; ex_is_load = i.load; jump_or_branch = i.jb;
        s.name = nm; s.d2 = d2; s.exp = e;
        sbq.push_back(s);
        @(negedge clk);
        check_out();
    endtask

    in_t z, m;

    initial begin
        z = mk(0, 0, 0, 0, 0, 0, 0, 0);
        m = mk(0, 0, 0, 0, 1, 0, 0, 0);
        vecs[0]  = '{"idle",          z,                                6'b000000};
        vecs[1]  = '{"lu_rs2",        mk(0, 7, 0, 1, 0, 7, 1, 0),       6'b101000};
        vecs[2]  = '{"lu_r0",         mk(0, 0, 0, 1, 0, 0, 1, 0),       6'b000000};
        vecs[3]  = '{"lu_rs1",        mk(3, 0, 1, 0, 0, 3, 1, 0),       6'b101000};
        vecs[4]  = '{"rs1_unused",    mk(3, 0, 0, 0, 0, 3, 1, 0),       6'b000000};
        vecs[5]  = '{"not_load",      mk(3, 3, 1, 1, 0, 3, 0, 0),       6'b000000};
        vecs[6]  = '{"reg_mismatch",  mk(6, 4, 1, 1, 0, 5, 1, 0),       6'b000000};
        vecs[7]  = '{"jump",          mk(0, 0, 0, 0, 0, 0, 0, 1),       6'b000100};
        vecs[8]  = '{"jump_lu",       mk(0, 9, 0, 1, 0, 9, 1, 1),       6'b000100};
        vecs[9]  = '{"jump_lu_mult",  mk(0, 9, 0, 1, 1, 9, 1, 1),       6'b000100};
        vecs[10] = '{"lu_mult",       mk(0, 9, 0, 1, 1, 9, 1, 0),       6'b101000};
        vecs[11] = '{"lu_r31",        mk(0, 31, 0, 1, 0, 31, 1, 0),     6'b101000};

        cyc("rst_a", m, 6'b000000, 1'b0, 1'b0);
        cyc("rst_b", m, 6'b000000, 1'b0, 1'b0);
        cyc("rst_rel", z, 6'b000000);

        for (int i = 0; i < 12; i++) cyc(vecs[i].name, vecs[i].in, vecs[i].exp);
        cyc("settle", z, 6'b000000);

        cyc("mul_t0", m, 6'b010000);
        cyc("mul_t1", m, 6'b010010);
        cyc("mul_t2", m, 6'b010010);
        cyc("mul_t3", m, 6'b000011);
        cyc("b2b_t4", m, 6'b010000);
        cyc("b2b_t5", m, 6'b010010);
        cyc("b2b_t6", m, 6'b010010);
        cyc("b2b_t7", m, 6'b000011);
        cyc("b2b_end", z, 6'b000000);

        cyc("abort_t0", m, 6'b010000);
        cyc("abort_t1", mk(0, 0, 0, 0, 1, 0, 0, 1), 6'b000110);
        cyc("abort_t2", z, 6'b000000);
        cyc("abort_t3", z, 6'b000000);

        cyc("pri_lu_mult", mk(0, 9, 0, 1, 1, 9, 1, 0), 6'b101000);
        cyc("pri_mul_t0", m, 6'b010000);
        cyc("pri_mul_t1", m, 6'b010010);
        cyc("pri_mul_t2", m, 6'b010010);
        cyc("pri_mul_t3", m, 6'b000011);
        cyc("pri_end", z, 6'b000000);

        cyc("rb_start", m, 6'b010000);
        cyc("rb_reset", m, 6'b000000, 1'b0, 1'b0);
        cyc("rb_idle", z, 6'b000000);
        cyc("rb_idle2", z, 6'b000000);

        cyc("mc2_t0", m, 6'b010000, 1'b1);
        cyc("mc2_t1", m, 6'b000011, 1'b1);
        cyc("mc2_t2", m, 6'b010000, 1'b1);
        cyc("mc2_t3", m, 6'b000011, 1'b1);
        cyc("mc2_end", z, 6'b000000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
